// File: rtl/dsram_axi_bridge_pkg.sv
// Shared definitions for dsram_axi_bridge: FSM state encodings, AXI constants,
// the latched request record and the default AXI ID.
package dsram_axi_bridge_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

  localparam logic [3:0] AXI_ID_DEFAULT = 4'd1;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  // sram-like size codes (byte/half/word) map directly onto AXI size codes.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/dsram_req_latch.sv
// Request field latch for dsram_axi_bridge: captures addr/size/wstrb/wdata on
// accept and holds them unchanged for the whole AXI transaction.
module dsram_req_latch
  import dsram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] wdata_i,
  output req_t        req_o
);

  req_t req_q, req_d;

  always_comb begin
    req_d = req_q;
    if (capture) begin
      req_d = '{addr: addr_i, size: size_i, wstrb: wstrb_i, wdata: wdata_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/dsram_axi_bridge.sv
// sram-like data port to single-beat AXI3 bridge, one transaction outstanding.
// Define DSRAM_WR_EARLY_OK_EN to complete stores once AW and W are both accepted.
module dsram_axi_bridge
  import dsram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = AXI_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [2:0]  dbg_state
);

  logic [2:0]  state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] rdata_q, rdata_d;
  logic        accept;
  req_t        req;
  logic        unused_inputs;

  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valids are pure functions of registered state, so they never drop before ready.
  assign data_addr_ok = (state_q == ST_IDLE) && !reset;
  assign accept       = data_req && data_addr_ok;

  dsram_req_latch u_req_latch (
    .clk     (clk),
    .reset   (reset),
    .capture (accept),
    .addr_i  (data_addr),
    .size_i  (data_size),
    .wstrb_i (data_wstrb),
    .wdata_i (data_wdata),
    .req_o   (req)
  );

  assign arvalid = (state_q == ST_RD_ADDR);
  assign rready  = (state_q == ST_RD_DATA);
  assign awvalid = (state_q == ST_WR_REQ) && !aw_done_q;
  assign wvalid  = (state_q == ST_WR_REQ) && !w_done_q;
  assign bready  = (state_q == ST_WR_RESP);

  assign arid    = AXI_ID;
  assign araddr  = req.addr;
  assign arsize  = axi_size(req.size);
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign awid    = AXI_ID;
  assign awaddr  = req.addr;
  assign awsize  = axi_size(req.size);
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid     = AXI_ID;
  assign wdata   = req.wdata;
  assign wstrb   = req.wstrb;
  assign wlast   = 1'b1;

  assign data_data_ok = data_ok_q;
  assign data_rdata   = rdata_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    data_ok_d = 1'b0;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (accept) begin
          state_d = data_wr ? ST_WR_REQ : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        if (arready) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (rvalid) begin
          rdata_d   = rdata;
          data_ok_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        // Each valid is high only while its done flag is clear, so ready alone marks the handshake.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) begin
          state_d   = ST_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef DSRAM_WR_EARLY_OK_EN
          data_ok_d = 1'b1;
`endif
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          state_d = ST_IDLE;
`ifndef DSRAM_WR_EARLY_OK_EN
          data_ok_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dsram_axi_bridge.sv
// Directed bench for dsram_axi_bridge; the bench acts as CPU and AXI slave.
// Expectations follow DSRAM_WR_EARLY_OK_EN when it is defined.
module tb_dsram_axi_bridge;
  import dsram_axi_bridge_pkg::*;

  logic        clk, reset;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot, dbg_state;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  logic [32:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int ok_seen = 0;
  int ok_popped = 0;
  logic [31:0] last_rdata;

  dsram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_state(dbg_state)
  );

  // Clock and completion-pulse monitor.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (!reset && data_data_ok) ok_seen++;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [32:0] e;
    check({tag, "_queue_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ok_popped++;
      if (e[32]) check({tag, "_rdata"}, data_rdata, e[31:0]);
    end
  endtask

  task automatic accept(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic [3:0] strb, input logic [31:0] wd, input logic [31:0] rd_exp);
    int n = 0;
    data_req = 1'b1; data_wr = wr; data_addr = addr; data_size = size;
    data_wstrb = strb; data_wdata = wd;
    while (!data_addr_ok && n < 10) begin
      step();
      n++;
    end
    check("accept_addr_ok", data_addr_ok, 1);
    exp_q.push_back({!wr, rd_exp});
    step();
    data_req = 1'b0; data_addr = ~addr; data_size = ~size; data_wstrb = ~strb; data_wdata = ~wd;
  endtask

  // Ends in the data_data_ok cycle; the caller decides what happens on the next edge.
  task automatic load_body(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] d,
                           input int ar_dly, input int r_dly);
    for (int i = 0; i < ar_dly; i++) begin
      check("ar_hold", arvalid, 1);
      check("addr_ok_busy_ar", data_addr_ok, 0);
      step();
    end
    check("arvalid", arvalid, 1);
    check("araddr", araddr, addr);
    check("arsize", arsize, {1'b0, size});
    check("arid", arid, 4'd1);
    check("addr_ok_busy_ar", data_addr_ok, 0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("arvalid_drop", arvalid, 0);
    for (int i = 0; i < r_dly; i++) begin
      check("rready_wait", rready, 1);
      check("ok_before_r", data_data_ok, 0);
      step();
    end
    check("rready", rready, 1);
    check("addr_ok_busy_r", data_addr_ok, 0);
    rvalid = 1'b1; rdata = d; rid = 4'd1; rlast = 1'b1;
    step();
    rvalid = 1'b0; rdata = 32'h0; rlast = 1'b0;
    check("load_ok", data_data_ok, 1);
    pop_check("load");
    last_rdata = d;
  endtask

  task automatic idle_after_load(input logic [31:0] d);
    step();
    check("ok_single_pulse", data_data_ok, 0);
    check("rdata_hold", data_rdata, d);
  endtask

  task automatic store_body(input logic [31:0] addr, input logic [1:0] size, input logic [3:0] strb,
                            input logic [31:0] wd, input int aw_dly, input int w_dly, input int b_dly);
    int aw_hs = 0;
    int w_hs = 0;
    int last = (aw_dly > w_dly) ? aw_dly : w_dly;
    for (int c = 0; c <= last; c++) begin
      check("awvalid_seq", awvalid, 32'(c <= aw_dly));
      check("wvalid_seq", wvalid, 32'(c <= w_dly));
      check("addr_ok_busy_w", data_addr_ok, 0);
      if (c <= aw_dly) begin
        check("awaddr", awaddr, addr);
        check("awsize", awsize, {1'b0, size});
      end
      if (c <= w_dly) begin
        check("wdata", wdata, wd);
        check("wstrb", wstrb, strb);
        check("wlast", wlast, 1);
      end
      awready = (c == aw_dly);
      wready  = (c == w_dly);
      if (awvalid && awready) aw_hs++;
      if (wvalid && wready) w_hs++;
      step();
    end
    awready = 1'b0; wready = 1'b0;
    check("aw_handshakes", aw_hs, 1);
    check("w_handshakes", w_hs, 1);
    check("bready", bready, 1);
    check("aw_w_valid_drop", {awvalid, wvalid}, 0);
`ifdef DSRAM_WR_EARLY_OK_EN
    check("early_ok", data_data_ok, 1);
    pop_check("store_early");
`endif
    for (int i = 0; i < b_dly; i++) begin
      check("addr_ok_wait_b", data_addr_ok, 0);
`ifdef DSRAM_WR_EARLY_OK_EN
      if (i > 0) check("no_extra_ok", data_data_ok, 0);
`else
      check("ok_before_b", data_data_ok, 0);
`endif
      step();
    end
    bvalid = 1'b1; bid = 4'd1;
    step();
    bvalid = 1'b0;
`ifdef DSRAM_WR_EARLY_OK_EN
    check("no_second_ok", data_data_ok, 0);
`else
    check("store_ok", data_data_ok, 1);
    pop_check("store");
`endif
    check("addr_ok_after_b", data_addr_ok, 1);
  endtask

  initial begin
    logic [31:0] a, d;
    reset = 1'b1;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0;
    data_wstrb = 4'h0; data_wdata = 32'h0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rid = 4'd0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    bid = 4'd0; bresp = 2'b00; bvalid = 1'b0;
    last_rdata = 32'h0;
    step();
    step();
    check("rst_addr_ok", data_addr_ok, 0);
    check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    check("rst_data_ok", data_data_ok, 0);
    check("rst_rdata", data_rdata, 32'h0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    step();
    check("idle_addr_ok", data_addr_ok, 1);
    check("const_len", {arlen, awlen}, 0);
    check("const_burst", {arburst, awburst}, 4'b0101);

    // Load with arready delayed 3 cycles.
    accept(1'b0, 32'h1FC0_0010, 2'd2, 4'h0, 32'h0, 32'hDEAD_BEEF);
    load_body(32'h1FC0_0010, 2'd2, 32'hDEAD_BEEF, 3, 0);
    idle_after_load(32'hDEAD_BEEF);

    // Byte store, wready two cycles ahead of awready.
    accept(1'b1, 32'h0000_0103, 2'd0, 4'b1000, 32'h5500_0000, 32'h0);
    store_body(32'h0000_0103, 2'd0, 4'b1000, 32'h5500_0000, 3, 1, 0);
    step();
    check("store_ok_single", data_data_ok, 0);

    // Back-to-back load then store with data_req held; zero-wait slave.
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2000; data_size = 2'd2;
    check("b2b_accept1", data_addr_ok, 1);
    exp_q.push_back({1'b1, 32'h1234_5678});
    step();
    data_wr = 1'b1; data_addr = 32'h0000_3004; data_wstrb = 4'hF; data_wdata = 32'hCAFE_F00D;
    load_body(32'h0000_2000, 2'd2, 32'h1234_5678, 0, 0);
    check("b2b_accept2", data_addr_ok, 1);
    exp_q.push_back({1'b0, 32'h0});
    step();
    data_req = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;
    store_body(32'h0000_3004, 2'd2, 4'hF, 32'hCAFE_F00D, 0, 0, 0);
    step();

    // Reset while waiting in RD_DATA.
    accept(1'b0, 32'h0000_0100, 2'd2, 4'h0, 32'h0, 32'h0);
    check("rst_mid_arvalid", arvalid, 1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("rst_mid_rready", rready, 1);
    reset = 1'b1;
    step();
    check("rst_mid_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    check("rst_mid_ok", data_data_ok, 0);
    check("rst_mid_state", dbg_state, ST_IDLE);
    void'(exp_q.pop_back());
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mid_no_ok", data_data_ok, 0);
    end
    accept(1'b0, 32'h0000_0200, 2'd2, 4'h0, 32'h0, 32'hA5A5_0001);
    load_body(32'h0000_0200, 2'd2, 32'hA5A5_0001, 1, 2);
    idle_after_load(32'hA5A5_0001);

    // Store with bvalid 5 cycles late.
    accept(1'b1, 32'h0000_0040, 2'd1, 4'b0011, 32'h0000_BEEF, 32'h0);
    store_body(32'h0000_0040, 2'd1, 4'b0011, 32'h0000_BEEF, 0, 0, 5);
    step();

    // Spurious responses while idle.
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    check("spur_b_ok", data_data_ok, 0);
    check("spur_b_state", dbg_state, ST_IDLE);
    check("spur_b_addr_ok", data_addr_ok, 1);
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    step();
    rvalid = 1'b0; rdata = 32'h0;
    step();
    check("spur_r_ok", data_data_ok, 0);
    check("spur_r_rdata", data_rdata, last_rdata);

    // Randomised mix of loads and stores.
    for (int k = 0; k < 6; k++) begin
      a = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        accept(1'b0, a, 2'd2, 4'h0, 32'h0, d);
        load_body(a, 2'd2, d, $urandom_range(0, 3), $urandom_range(0, 3));
        idle_after_load(d);
      end else begin
        accept(1'b1, a, 2'd2, 4'hF, d, 32'h0);
        store_body(a, 2'd2, 4'hF, d, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3));
        step();
      end
    end

    step();
    check("ok_pulse_count", ok_seen, ok_popped);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dsram_axi_bridge.md
# dsram_axi_bridge

Data-side responder for the CPU's sram-like data interface. It accepts one load/store request at a time from EXE (addr_ok handshake), converts it into a single-beat AXI3 read or write transaction, and returns completion plus load data to MEM through data_data_ok/data_rdata. It sits between the pipeline's data port and the AXI crossbar, with exactly one transaction outstanding.

## Interface
Parameters:
- AXI_ID, 4'd1: ID driven on arid/awid/wid.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- data_req  input  1  request valid from EXE
- data_wr  input  1  1 = store, 0 = load
- data_size  input  2  0 byte, 1 half, 2 word; driven onto arsize/awsize
- data_addr  input  32  byte address, passed unmodified
- data_wstrb  input  4  store byte enables (swl/swr masks allowed)
- data_wdata  input  32  store data, already lane-aligned
- data_addr_ok  output  1  request accepted this cycle when data_req=1
- data_data_ok  output  1  one-cycle completion pulse
- data_rdata  output  32  load data, valid while data_data_ok=1
- arid/araddr/arsize/arvalid  output  4/32/3/1  AR channel
- arready  input  1
- rid/rdata/rresp/rlast/rvalid  input  4/32/2/1/1  R channel; rresp ignored
- rready  output  1
- awid/awaddr/awsize/awvalid  output  4/32/3/1  AW channel
- awready  input  1
- wid/wdata/wstrb/wlast/wvalid  output  4/32/4/1/1  W channel; wlast tied 1
- wready  input  1
- bid/bresp/bvalid  input  4/2/1  B channel; bresp ignored
- bready  output  1
- Constant outputs: arlen/awlen=0, arburst/awburst=2'b01, arlock/awlock=0, arcache/awcache=0, arprot/awprot=0.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE: data_addr_ok=1 (forced 0 while reset=1). On data_req&&data_addr_ok latch addr, size, wstrb, wdata; go RD_ADDR if data_wr=0, else WR_REQ.
- RD_ADDR: arvalid=1 from latched fields; arvalid&&arready -> RD_DATA.
- RD_DATA: rready=1; rvalid -> register rdata into data_rdata, pulse data_data_ok next cycle, go IDLE.
- WR_REQ: awvalid and wvalid raised together; flags aw_done/w_done record each handshake and drop the matching valid; same-cycle or either order accepted; both done -> WR_RESP.
- WR_RESP: bready=1; bvalid -> pulse data_data_ok next cycle, go IDLE.
- araddr/awaddr and arsize/awsize come only from the latch, never from live inputs; AXI valids never deassert before their ready.
- data_rdata holds its last value between loads; undefined for stores.

## Timing
- Reset: state IDLE; arvalid, awvalid, wvalid, rready, bready, data_data_ok, aw_done, w_done = 0; data_rdata = 0.
- Load latency with zero-wait slave: accept cycle T, arvalid T+1, rvalid T+2, data_data_ok T+3.
- Store latency: accept T, aw/w valid T+1, bvalid T+2, data_data_ok T+3.
- data_data_ok cycle is in IDLE: a new request may be accepted in that same cycle.
- data_addr_ok=0 in every non-IDLE state; a held data_req waits.
- Reset mid-transaction drops all valids next edge, returns to IDLE, no data_data_ok issued; the AXI slave shares the reset.
- rvalid/bvalid outside RD_DATA/WR_RESP are ignored.

## Configuration
- DSRAM_WR_EARLY_OK_EN defined: store data_data_ok pulses the cycle after both aw_done and w_done; FSM still waits in WR_RESP for bvalid before data_addr_ok returns to 1, and no second pulse is issued at B.
- Undefined: store data_data_ok only after the B handshake, as in Operation.

## Structure
- Shared package header: FSM state encodings, AXI burst/size constants, AXI_ID default.
- One sub-module, dsram_req_latch: captures request fields on accept and holds them for the transaction.

## Test plan
- Load word addr 0x1FC0_0010, slave returns 0xDEAD_BEEF after arready delay 3 -> one data_data_ok with data_rdata=0xDEAD_BEEF, arsize=2, araddr=0x1FC0_0010.
- Store size 0 addr 0x0000_0103 wstrb 4'b1000 wdata 0x5500_0000, wready 2 cycles before awready -> single AW and W handshake each, one data_data_ok after bvalid.
- Back-to-back load then store with data_req held high -> second accept in data_data_ok cycle, data_addr_ok low throughout first transaction.
- Reset asserted in RD_DATA before rvalid -> all valids 0 next cycle, no data_data_ok, next load completes normally.
- DSRAM_WR_EARLY_OK_EN: store with bvalid delayed 5 cycles -> data_data_ok the cycle after AW/W done, data_addr_ok stays 0 until B received.
- Spurious bvalid pulse while in IDLE -> no data_data_ok, state unchanged.
